// File: rtl/mem_responder_pkg.sv
// Shared constants and state encoding for the memory responder.
package mem_responder_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESPOND
  } state_t;

  localparam logic [15:0] RAM_TOP_DEF    = 16'hEFFF;
  localparam logic [15:0] LED_ADDR_DEF   = 16'hFFF0;
  localparam logic [15:0] SW_ADDR_DEF    = 16'hFFF1;
  localparam logic [15:0] TIMER_ADDR_DEF = 16'hFFF2;
  localparam logic [15:0] IO_BASE        = 16'hF000;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control FSM, the responder and the RAM.
interface mem_responder_if;
  logic        memEnable;
  logic        memWriteEnable;
  logic [15:0] address;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        ready;
  logic        ramEnable;
  logic        ramWrite;
  logic [15:0] ramAddr;
  logic [15:0] ramWriteData;
  logic [15:0] ramReadData;

  modport slave (
    input  memEnable, memWriteEnable, address, writeData, ramReadData,
    output readData, ready, ramEnable, ramWrite, ramAddr, ramWriteData
  );

  modport master (
    output memEnable, memWriteEnable, address, writeData, ramReadData,
    input  readData, ready, ramEnable, ramWrite, ramAddr, ramWriteData
  );
endinterface

// File: rtl/mem_responder_io_regs.sv
// Memory-mapped I/O: LED register, free-running timer and the I/O read mux.
module io_regs
  import mem_responder_pkg::*;
#(
  parameter logic [15:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [15:0] SW_ADDR    = SW_ADDR_DEF,
  parameter logic [15:0] TIMER_ADDR = TIMER_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_switches,
  output logic [15:0] o_leds,
  output logic [15:0] o_rdata
);
  logic [15:0] r_leds;
  logic [15:0] r_timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_leds  <= '0;
      r_timer <= '0;
    end else begin
      if (i_wr && i_addr == LED_ADDR) r_leds <= i_wdata;
      // A write replaces the increment on that edge.
      if (i_wr && i_addr == TIMER_ADDR) r_timer <= i_wdata;
      else                              r_timer <= r_timer + 16'd1;
    end
  end

  always_comb begin
    o_rdata = '0;
    if      (i_addr == LED_ADDR)   o_rdata = r_leds;
    else if (i_addr == SW_ADDR)    o_rdata = i_switches;
    else if (i_addr == TIMER_ADDR) o_rdata = r_timer;
  end

  assign o_leds = r_leds;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: routes control-FSM requests to RAM or the I/O registers
// and returns a one-cycle ready pulse per transaction.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [15:0] RAM_TOP    = RAM_TOP_DEF,
  parameter logic [15:0] LED_ADDR   = LED_ADDR_DEF,
  parameter logic [15:0] SW_ADDR    = SW_ADDR_DEF,
  parameter logic [15:0] TIMER_ADDR = TIMER_ADDR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus,
  input  logic [15:0]     switches,
  output logic [15:0]     leds
);
  state_t      r_state, w_state_nxt;
  logic        r_we;
  logic [15:0] r_addr, r_wdata, r_read_data;
  logic        r_ready, r_ram_en, r_ram_wr;
  logic [15:0] r_ram_addr, r_ram_wdata;
  logic        w_accept, w_ram_go, w_cur_ram, w_io_wr, w_io_rd, w_ready_nxt;
  logic [15:0] w_io_rdata;

  assign w_cur_ram = (r_addr <= RAM_TOP);
  assign w_io_wr   = (r_state == S_ACCESS) && !w_cur_ram && r_we;
  assign w_io_rd   = (r_state == S_ACCESS) && !w_cur_ram && !r_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ram_go    = 1'b0;
    w_ready_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (bus.memEnable) begin
        w_accept    = 1'b1;
        w_ram_go    = (bus.address <= RAM_TOP);
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        // RAM reads need one extra cycle for the RAM to return data.
        if (w_cur_ram && !r_we) w_state_nxt = S_CAPTURE;
        else begin
          w_state_nxt = S_RESPOND;
          w_ready_nxt = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_RESPOND;
        w_ready_nxt = 1'b1;
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ready     <= w_ready_nxt;
      r_ram_en    <= w_ram_go;
      r_ram_wr    <= w_ram_go && bus.memWriteEnable;
      r_ram_addr  <= w_ram_go ? bus.address   : '0;
      r_ram_wdata <= w_ram_go ? bus.writeData : '0;
      if (w_accept) begin
        r_we    <= bus.memWriteEnable;
        r_addr  <= bus.address;
        r_wdata <= bus.writeData;
      end
      if (r_state == S_CAPTURE) r_read_data <= bus.ramReadData;
      else if (w_io_rd)         r_read_data <= w_io_rdata;
    end
  end

  io_regs #(
    .LED_ADDR   (LED_ADDR),
    .SW_ADDR    (SW_ADDR),
    .TIMER_ADDR (TIMER_ADDR)
  ) u_io (
    .clock      (clock),
    .reset      (reset),
    .i_wr       (w_io_wr),
    .i_addr     (r_addr),
    .i_wdata    (r_wdata),
    .i_switches (switches),
    .o_leds     (leds),
    .o_rdata    (w_io_rdata)
  );

  assign bus.readData     = r_read_data;
  assign bus.ready        = r_ready;
  assign bus.ramEnable    = r_ram_en;
  assign bus.ramWrite     = r_ram_wr;
  assign bus.ramAddr      = r_ram_addr;
  assign bus.ramWriteData = r_ram_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a small RAM model and a
// scoreboard of expected completions.
module tb_mem_responder;
  logic        clock;
  logic        reset;
  logic [15:0] switches;
  logic [15:0] leds;

  mem_responder_if bus();

  mem_responder dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds)
  );

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    int          lat;
  } sb_t;

  sb_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rdy_cnt = 0;
  int          ram_en_cnt = 0;
  int          ram_wr_cnt = 0;
  logic [15:0] mem [256];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: one-cycle read latency.
  always @(posedge clock) begin
    if (bus.ramEnable === 1'b1) begin
      if (bus.ramWrite === 1'b1) mem[bus.ramAddr[7:0]] <= bus.ramWriteData;
      else                       bus.ramReadData <= mem[bus.ramAddr[7:0]];
    end
  end

  always @(posedge clock) begin
    cyc++;
    if (bus.ready === 1'b1)     rdy_cnt++;
    if (bus.ramEnable === 1'b1) ram_en_cnt++;
    if (bus.ramWrite === 1'b1)  ram_wr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Caller is at a negedge in an IDLE cycle; returns at the negedge after RESPOND.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input int exp_lat, input logic exp_ram,
                       input string nm, output int rdy_cyc);
    sb_t e;
    int  lat, en0, wr0;
    e.is_read = !we; e.data = exp_rd; e.lat = exp_lat;
    exp_q.push_back(e);
    en0 = ram_en_cnt; wr0 = ram_wr_cnt;
    bus.memEnable = 1'b1; bus.memWriteEnable = we; bus.address = a; bus.writeData = d;
    @(negedge clock);
    bus.memEnable = 1'b0;
    n_cmp++;
    if (bus.ramEnable !== exp_ram ||
        (exp_ram && (bus.ramWrite !== we || bus.ramAddr !== a || bus.ramWriteData !== d))) begin
      n_err++;
      $display("FAIL %s strobe: en=%b wr=%b addr=%h wd=%h, expected en=%b wr=%b addr=%h wd=%h",
               nm, bus.ramEnable, bus.ramWrite, bus.ramAddr, bus.ramWriteData, exp_ram, we, a, d);
    end
    lat = 1;
    while (bus.ready !== 1'b1 && lat < 16) begin
      @(negedge clock);
      lat++;
    end
    rdy_cyc = cyc;
    e = exp_q.pop_front();
    n_cmp++;
    if (lat != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, lat, e.lat);
    end
    if (e.is_read) begin
      n_cmp++;
      if (bus.readData !== e.data) begin
        n_err++;
        $display("FAIL %s readData: got %h, expected %h", nm, bus.readData, e.data);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (bus.ready !== 1'b0 || (ram_en_cnt - en0) != (exp_ram ? 1 : 0) ||
        (ram_wr_cnt - wr0) != ((exp_ram && we) ? 1 : 0)) begin
      n_err++;
      $display("FAIL %s pulses: ready=%b ram_en=%0d ram_wr=%0d, expected ready=0 ram_en=%0d ram_wr=%0d",
               nm, bus.ready, ram_en_cnt - en0, ram_wr_cnt - wr0,
               exp_ram ? 1 : 0, (exp_ram && we) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({bus.readData, leds, bus.ramAddr, bus.ramWriteData} !== 64'h0 ||
        {bus.ready, bus.ramEnable, bus.ramWrite} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_state: rd=%h leds=%h ra=%h rwd=%h rdy=%b en=%b wr=%b, expected all zero",
               bus.readData, leds, bus.ramAddr, bus.ramWriteData, bus.ready, bus.ramEnable, bus.ramWrite);
    end
    reset = 1'b0;
  endtask

  task automatic test_ram_write();
    int c;
    issue(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2, 1'b1, "ram_write", c);
  endtask

  task automatic test_ram_read();
    int c;
    issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 1'b1, "ram_read", c);
  endtask

  task automatic test_led();
    int c;
    issue(1'b1, 16'hFFF0, 16'h00A5, 16'h0000, 2, 1'b0, "led_write", c);
    n_cmp++;
    if (leds !== 16'h00A5) begin
      n_err++;
      $display("FAIL led_value: got %h, expected 00a5", leds);
    end
    issue(1'b0, 16'hFFF0, 16'h0000, 16'h00A5, 2, 1'b0, "led_read", c);
  endtask

  task automatic test_timer();
    int          t_w, c;
    logic [15:0] e;
    issue(1'b1, 16'hFFF2, 16'hFFFE, 16'h0000, 2, 1'b0, "timer_write", t_w);
    // Timer reads FFFE during cycle t_w; sampled at the ACCESS edge (cycle cyc+1).
    e = 16'hFFFE + 16'(cyc + 1 - t_w);
    issue(1'b0, 16'hFFF2, 16'h0000, e, 2, 1'b0, "timer_wrap", c);
    repeat (5) @(negedge clock);
    e = 16'hFFFE + 16'(cyc + 1 - t_w);
    issue(1'b0, 16'hFFF2, 16'h0000, e, 2, 1'b0, "timer_later", c);
  endtask

  task automatic test_sw_unmapped();
    int c;
    switches = 16'h1234;
    issue(1'b0, 16'hFFF1, 16'h0000, 16'h1234, 2, 1'b0, "sw_read", c);
    issue(1'b1, 16'hFFF1, 16'h5555, 16'h0000, 2, 1'b0, "sw_write", c);
    n_cmp++;
    if (bus.readData !== 16'h1234) begin
      n_err++;
      $display("FAIL readData_hold: got %h, expected 1234", bus.readData);
    end
    issue(1'b0, 16'hFFF1, 16'h0000, 16'h1234, 2, 1'b0, "sw_reread", c);
    issue(1'b0, 16'hFFF7, 16'h0000, 16'h0000, 2, 1'b0, "unmapped_read", c);
    issue(1'b1, 16'hFFF7, 16'h7777, 16'h0000, 2, 1'b0, "unmapped_write", c);
    n_cmp++;
    if (leds !== 16'h00A5) begin
      n_err++;
      $display("FAIL leds_untouched: got %h, expected 00a5", leds);
    end
  endtask

  task automatic test_back_to_back();
    int r0, en0, wr0, c;
    r0 = rdy_cnt; en0 = ram_en_cnt; wr0 = ram_wr_cnt;
    bus.memEnable = 1'b1; bus.memWriteEnable = 1'b1;
    bus.address = 16'h0020; bus.writeData = 16'h1111;
    repeat (9) @(negedge clock);
    bus.memEnable = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (rdy_cnt - r0 != 3 || ram_en_cnt - en0 != 3 || ram_wr_cnt - wr0 != 3) begin
      n_err++;
      $display("FAIL back_to_back: ready=%0d ram_en=%0d ram_wr=%0d, expected 3 each",
               rdy_cnt - r0, ram_en_cnt - en0, ram_wr_cnt - wr0);
    end
    issue(1'b0, 16'h0020, 16'h0000, 16'h1111, 3, 1'b1, "b2b_readback", c);
  endtask

  task automatic test_reset_abort();
    int r0, c;
    r0 = rdy_cnt;
    bus.memEnable = 1'b1; bus.memWriteEnable = 1'b0; bus.address = 16'h0010;
    @(negedge clock);
    bus.memEnable = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.readData, leds, bus.ramAddr, bus.ramWriteData} !== 64'h0 ||
        {bus.ready, bus.ramEnable, bus.ramWrite} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_outputs: rd=%h leds=%h ra=%h rdy=%b en=%b wr=%b, expected all zero",
               bus.readData, leds, bus.ramAddr, bus.ready, bus.ramEnable, bus.ramWrite);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (rdy_cnt != r0) begin
      n_err++;
      $display("FAIL abort_no_ready: got %0d ready pulses, expected 0", rdy_cnt - r0);
    end
    reset = 1'b0;
    issue(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 1'b1, "post_reset_read", c);
  endtask

  initial begin
    reset = 1'b1;
    switches = 16'h0000;
    bus.memEnable = 1'b0;
    bus.memWriteEnable = 1'b0;
    bus.address = 16'h0000;
    bus.writeData = 16'h0000;
    test_reset();
    test_ram_write();
    test_ram_read();
    test_led();
    test_timer();
    test_sw_unmapped();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_TOP, default 16'hEFFF: highest word address routed to RAM; addresses above it are the I/O region.
REQ-002 Parameter LED_ADDR, default 16'hFFF0: LED output register address.
REQ-003 Parameter SW_ADDR, default 16'hFFF1: switch input address, read-only.
REQ-004 Parameter TIMER_ADDR, default 16'hFFF2: free-running timer address, read/write.
REQ-005 Ports:
- clock  in  1: sole clock; all state changes on posedge.
- reset  in  1: asynchronous, active-high.
- memEnable  in  1: request from the control FSM's memory port A enable.
- memWriteEnable  in  1: 1 = write, 0 = read; valid while memEnable=1.
- address  in  16: word address.
- writeData  in  16: store data.
- readData  out  16: load data.
- ready  out  1: one-cycle completion pulse.
- ramEnable  out  1: RAM port strobe.
- ramWrite  out  1: RAM write strobe.
- ramAddr  out  16: RAM address.
- ramWriteData  out  16: RAM write data.
- ramReadData  in  16: RAM data, valid one clock after a read strobe.
- switches  in  16: board switches.
- leds  out  16: LED register.

Function
REQ-006 FSM states: IDLE, ACCESS, CAPTURE, RESPOND; all outputs registered.
REQ-007 IDLE, memEnable=1 at edge N:
- latch address, writeData, memWriteEnable;
- go to ACCESS;
- for a RAM-region address, ramEnable=1, ramWrite=memWriteEnable, and ramAddr/ramWriteData driven during cycle N+1 only.
REQ-008 ACCESS, RAM write: write retires at edge N+1; go to RESPOND; ready=1 during cycle N+2.
REQ-009 ACCESS, RAM read: go to CAPTURE; at edge N+2 register ramReadData into readData; go to RESPOND; ready=1 during cycle N+3.
REQ-010 ACCESS, I/O-region access: ram strobes stay 0; register update or readData load at edge N+1; go to RESPOND; ready=1 during cycle N+2.
REQ-011 RESPOND lasts exactly one cycle, then IDLE unconditionally.
REQ-012 readData holds its value until the next completed read.
REQ-013 memEnable is ignored outside IDLE.
REQ-014 Back-to-back requests: a request held high through RESPOND is accepted again at the first IDLE edge; each ready pulse is one transaction.
REQ-015 I/O reads:
- LED_ADDR returns leds;
- SW_ADDR returns switches, sampled at the ACCESS edge;
- TIMER_ADDR returns the timer value at the ACCESS edge;
- any other I/O address returns 16'h0000.
REQ-016 I/O writes:
- LED_ADDR loads leds;
- TIMER_ADDR loads the timer;
- SW_ADDR and unmapped I/O writes are ignored but still pulse ready.
REQ-017 Timer increments by 1 every clock and wraps 16'hFFFF->16'h0000.
REQ-018 A timer write overrides the increment on that edge; the timer reads the written value on the following cycle.
REQ-019 Address decode is unsigned: address<=RAM_TOP is RAM; 16'hF000..16'hFFFF is I/O.

Reset
REQ-020 While reset=1, independent of clock:
- state=IDLE;
- readData, leds, timer, ramAddr, ramWriteData = 16'h0000;
- ready, ramEnable, ramWrite = 0.
REQ-021 Reset mid-transaction aborts it: no ready pulse, no RAM strobe, no register write after reset asserts.
REQ-022 First request acceptance is at the first posedge after reset deasserts.

Structure
REQ-023 A shared package holds:
- state encoding;
- RAM_TOP, LED_ADDR, SW_ADDR, TIMER_ADDR defaults;
- the I/O base constant 16'hF000.
REQ-024 One sub-module, io_regs, holds the LED register, timer and I/O read mux; the FSM and RAM strobes stay in mem_responder.

Verification
REQ-025 RAM write: address=16'h0010, writeData=16'hBEEF, write, memEnable 1 cycle -> ramEnable=ramWrite=1, ramAddr=16'h0010 for exactly one cycle; ready at N+2.
REQ-026 RAM read: read 16'h0010, model returns 16'hBEEF -> readData=16'hBEEF with ready at N+3; ramWrite=0 throughout.
REQ-027 LED round-trip: write 16'h00A5 to 16'hFFF0, then read 16'hFFF0 -> leds=16'h00A5 after the first ready; read returns 16'h00A5; ram strobes never assert.
REQ-028 Timer: write 16'hFFFE to 16'hFFF2; read next cycle after ready -> value is 16'hFFFE plus elapsed cycles mod 2^16, showing the wrap through 16'h0000.
REQ-029 Unmapped and switch access: switches=16'h1234; read 16'hFFF1 -> 16'h1234; write 16'hFFF1 -> ready pulses, switch value unchanged; read 16'hFFF7 -> 16'h0000.
REQ-030 Reset abort: assert reset during CAPTURE of a read -> no ready pulse, all outputs 16'h0000/0 immediately; a new read issued after release completes normally.
